// File: rtl/prim_subreg_mhw_if.sv
// Register-slice bus: SW decode strobes, HW writer channels and the slice outputs.
interface prim_subreg_mhw_if #(
  parameter int unsigned DW    = 32,
  parameter int unsigned NumHw = 2
);
  logic                  we;
  logic [DW-1:0]         wd;
  logic                  re;
  logic [NumHw-1:0]      de;
  logic [NumHw*DW-1:0]   d;
  logic [NumHw-1:0]      de_ack;
  logic [DW-1:0]         q;
  logic                  qe;
  logic                  err_update;
  logic                  err_storage;

  modport master (
    output we, wd, re, de, d,
    input  de_ack, q, qe, err_update, err_storage
  );

  modport slave (
    input  we, wd, re, de, d,
    output de_ack, q, qe, err_update, err_storage
  );
endinterface

// File: rtl/prim_subreg_mhw.sv
// Register slice with SW access policy, round-robin HW writers and optional
// shadowed two-write commit with an inverted integrity copy.
module prim_subreg_mhw #(
  parameter int unsigned   DW       = 32,
  parameter string         SwAccess = "RW",
  parameter int unsigned   NumHw    = 2,
  parameter logic [DW-1:0] RESVAL   = '0,
  parameter bit            Shadowed = 1'b0
) (
  input logic              clk_i,
  input logic              rst_i,
  prim_subreg_mhw_if.slave bus
);

  localparam bit IsRw  = (SwAccess == "RW");
  localparam bit IsWo  = (SwAccess == "WO");
  localparam bit IsRo  = (SwAccess == "RO");
  localparam bit IsW1c = (SwAccess == "W1C");
  localparam bit IsW1s = (SwAccess == "W1S");
  localparam bit IsW0c = (SwAccess == "W0C");
  localparam bit IsRc  = (SwAccess == "RC");
  localparam bit ShadowEn = Shadowed && !IsRo && !IsRc;
  localparam int unsigned PtrW = (NumHw > 1) ? $clog2(NumHw) : 1;

  typedef enum logic {StIdle, StStaged} state_e;

  logic [DW-1:0]    r_q, r_shadow, r_stage;
  state_e           r_state;
  logic [PtrW-1:0]  r_rr_ptr;
  logic             r_qe, r_err_update, r_err_storage;

  logic             w_cand_vld;
  logic [PtrW-1:0]  w_cand_idx, w_ptr_nxt;
  logic [DW-1:0]    w_base, w_next;
  logic             w_swc, w_ack, w_upd, w_stage_match;
  logic [NumHw-1:0] w_ack_vec;

  // Search from the round-robin pointer upward, wrapping at NumHw.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    w_cand_vld = 1'b0;
    w_cand_idx = '0;
    for (int unsigned k = 0; k < NumHw; k++) begin
      idx = 32'(r_rr_ptr) + k;
      if (idx >= NumHw) idx = idx - NumHw;
      if (!w_cand_vld && bus.de[idx[PtrW-1:0]]) begin
        w_cand_vld = 1'b1;
        w_cand_idx = idx[PtrW-1:0];
      end
    end
  end

  always_comb begin
    w_stage_match = (bus.wd == r_stage);
    w_base = w_cand_vld ? bus.d[32'(w_cand_idx) * DW +: DW] : r_q;
    if (ShadowEn)  w_swc = (r_state == StStaged) && bus.we && w_stage_match;
    else if (IsRc) w_swc = bus.re;
    else if (IsRo) w_swc = 1'b0;
    else           w_swc = bus.we;

    // RW/WO let SW take the whole word; the other policies merge per bit.
    w_ack = w_cand_vld && !(w_swc && (IsRw || IsWo));

    if (IsRw || IsWo) w_next = w_swc ? bus.wd : w_base;
    else if (IsW1s)   w_next = w_base | (w_swc ? bus.wd : '0);
    else if (IsW1c)   w_next = w_base & (w_swc ? ~bus.wd : '1);
    else if (IsW0c)   w_next = w_base & (w_swc ? bus.wd : '1);
    else if (IsRc)    w_next = w_base & (w_swc ? '0 : '1);
    else              w_next = w_base;

    w_upd     = w_swc || w_ack;
    w_ptr_nxt = (32'(w_cand_idx) == NumHw - 1) ? '0 : w_cand_idx + 1'b1;
    w_ack_vec = '0;
    if (w_ack) w_ack_vec[w_cand_idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_q           <= RESVAL;
      r_shadow      <= ~RESVAL;
      r_stage       <= '0;
      r_state       <= StIdle;
      r_rr_ptr      <= '0;
      r_qe          <= 1'b0;
      r_err_update  <= 1'b0;
      r_err_storage <= 1'b0;
    end else begin
      if (w_upd) begin
        r_q      <= w_next;
        r_shadow <= ~w_next;
      end
      if (w_ack) r_rr_ptr <= w_ptr_nxt;
      r_qe          <= w_swc;
      r_err_update  <= 1'b0;
      r_err_storage <= r_err_storage | (r_q != ~r_shadow);
      if (ShadowEn) begin
        unique case (r_state)
          StIdle: begin
            if (bus.we) begin
              r_stage <= bus.wd;
              r_state <= StStaged;
            end
          end
          StStaged: begin
            if (bus.we) begin
              r_state      <= StIdle;
              r_err_update <= !w_stage_match;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign bus.de_ack      = w_ack_vec;
  assign bus.q           = r_q;
  assign bus.qe          = r_qe;
  assign bus.err_update  = r_err_update;
  assign bus.err_storage = r_err_storage;

endmodule

// File: tb/tb_prim_subreg_mhw.sv
// Directed bench: RW table plus W1C, RC and shadowed-RW sequences on 8-bit slices.
module tb_prim_subreg_mhw;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  prim_subreg_mhw_if #(.DW(8), .NumHw(2)) if_rw ();
  prim_subreg_mhw_if #(.DW(8), .NumHw(2)) if_w1c ();
  prim_subreg_mhw_if #(.DW(8), .NumHw(2)) if_rc ();
  prim_subreg_mhw_if #(.DW(8), .NumHw(2)) if_sh ();

  prim_subreg_mhw #(.DW(8), .SwAccess("RW"), .NumHw(2), .RESVAL(8'h00), .Shadowed(1'b0)) u_rw (
    .clk_i(clk), .rst_i(rst), .bus(if_rw));
  prim_subreg_mhw #(.DW(8), .SwAccess("W1C"), .NumHw(2), .RESVAL(8'hFF), .Shadowed(1'b0)) u_w1c (
    .clk_i(clk), .rst_i(rst), .bus(if_w1c));
  prim_subreg_mhw #(.DW(8), .SwAccess("RC"), .NumHw(2), .RESVAL(8'h3C), .Shadowed(1'b0)) u_rc (
    .clk_i(clk), .rst_i(rst), .bus(if_rc));
  prim_subreg_mhw #(.DW(8), .SwAccess("RW"), .NumHw(2), .RESVAL(8'h00), .Shadowed(1'b1)) u_sh (
    .clk_i(clk), .rst_i(rst), .bus(if_sh));

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic [1:0] de;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] ack;
    logic [7:0] q;
    logic       qe;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if_rw.we = 0;  if_rw.wd = '0;  if_rw.re = 0;  if_rw.de = '0;  if_rw.d = '0;
    if_w1c.we = 0; if_w1c.wd = '0; if_w1c.re = 0; if_w1c.de = '0; if_w1c.d = '0;
    if_rc.we = 0;  if_rc.wd = '0;  if_rc.re = 0;  if_rc.de = '0;  if_rc.d = '0;
    if_sh.we = 0;  if_sh.wd = '0;  if_sh.re = 0;  if_sh.de = '0;  if_sh.d = '0;
  endtask

  initial begin
    //        we  wd     de     d0     d1     ack    q      qe
    tbl[0] = '{1'b0, 8'h00, 2'b11, 8'h0A, 8'h0B, 2'b01, 8'h0A, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 2'b11, 8'h0A, 8'h0B, 2'b10, 8'h0B, 1'b0};
    tbl[2] = '{1'b1, 8'h05, 2'b01, 8'h0C, 8'h00, 2'b00, 8'h05, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 2'b10, 8'h00, 8'h33, 2'b10, 8'h33, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 2'b00, 8'h11, 8'h22, 2'b00, 8'h33, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 2'b01, 8'h44, 8'h00, 2'b01, 8'h44, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 2'b01, 8'h45, 8'h00, 2'b01, 8'h45, 1'b0};
    tbl[7] = '{1'b1, 8'hAA, 2'b00, 8'h00, 8'h00, 2'b00, 8'hAA, 1'b1};

    idle_all();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_rw_q", 32'(if_rw.q), 32'h00);
    chk("rst_w1c_q", 32'(if_w1c.q), 32'hFF);
    chk("rst_rc_q", 32'(if_rc.q), 32'h3C);
    chk("rst_sh_q", 32'(if_sh.q), 32'h00);
    chk("rst_rw_qe", 32'(if_rw.qe), 32'h0);
    chk("rst_sh_errs", 32'({if_sh.err_update, if_sh.err_storage}), 32'h0);
    rst = 1'b0;

    // RW table
    for (int i = 0; i < 8; i++) begin
      if_rw.we = tbl[i].we;
      if_rw.wd = tbl[i].wd;
      if_rw.de = tbl[i].de;
      if_rw.d  = {tbl[i].d1, tbl[i].d0};
      #1;
      chk($sformatf("rw_ack[%0d]", i), 32'(if_rw.de_ack), 32'(tbl[i].ack));
      tick();
      chk($sformatf("rw_q[%0d]", i), 32'(if_rw.q), 32'(tbl[i].q));
      chk($sformatf("rw_qe[%0d]", i), 32'(if_rw.qe), 32'(tbl[i].qe));
      idle_all();
    end

    // W1C: SW clear of low nibble merged over HW data
    if_w1c.we = 1; if_w1c.wd = 8'h0F; if_w1c.de = 2'b01; if_w1c.d = {8'h00, 8'hF0};
    #1;
    chk("w1c_ack", 32'(if_w1c.de_ack), 32'h1);
    tick();
    chk("w1c_q", 32'(if_w1c.q), 32'hF0);
    chk("w1c_qe", 32'(if_w1c.qe), 32'h1);
    idle_all();
    if_w1c.we = 1; if_w1c.wd = 8'h30;
    tick();
    chk("w1c_q2", 32'(if_w1c.q), 32'hC0);
    idle_all();

    // RC
    if_rc.re = 1;
    #1;
    chk("rc_ack0", 32'(if_rc.de_ack), 32'h0);
    tick();
    chk("rc_q0", 32'(if_rc.q), 32'h00);
    chk("rc_qe0", 32'(if_rc.qe), 32'h1);
    idle_all();
    if_rc.de = 2'b10; if_rc.d = {8'h81, 8'h00};
    tick();
    chk("rc_hw", 32'(if_rc.q), 32'h81);
    chk("rc_hw_qe", 32'(if_rc.qe), 32'h0);
    if_rc.re = 1;
    #1;
    chk("rc_ack1", 32'(if_rc.de_ack), 32'h2);
    tick();
    chk("rc_q1", 32'(if_rc.q), 32'h00);
    idle_all();

    // Shadowed: matching pair commits once
    if_sh.we = 1; if_sh.wd = 8'h12;
    tick();
    chk("sh_first", 32'(if_sh.q), 32'h00);
    chk("sh_first_qe", 32'(if_sh.qe), 32'h0);
    tick();
    chk("sh_commit", 32'(if_sh.q), 32'h12);
    chk("sh_commit_qe", 32'(if_sh.qe), 32'h1);
    idle_all();
    tick();
    chk("sh_qe_once", 32'(if_sh.qe), 32'h0);

    // Shadowed: mismatch
    if_sh.we = 1; if_sh.wd = 8'h12;
    tick();
    if_sh.wd = 8'h13;
    tick();
    chk("sh_mis_q", 32'(if_sh.q), 32'h12);
    chk("sh_err_upd", 32'(if_sh.err_update), 32'h1);
    idle_all();
    tick();
    chk("sh_err_upd_pulse", 32'(if_sh.err_update), 32'h0);
    if_sh.we = 1; if_sh.wd = 8'h13;
    tick();
    chk("sh_back_idle", 32'(if_sh.q), 32'h12);
    tick();
    chk("sh_commit13", 32'(if_sh.q), 32'h13);
    idle_all();

    // Shadowed: HW write while staged
    if_sh.we = 1; if_sh.wd = 8'h55;
    tick();
    idle_all();
    if_sh.de = 2'b01; if_sh.d = {8'h00, 8'h77};
    #1;
    chk("sh_hw_ack", 32'(if_sh.de_ack), 32'h1);
    tick();
    chk("sh_hw_q", 32'(if_sh.q), 32'h77);
    chk("sh_hw_qe", 32'(if_sh.qe), 32'h0);
    idle_all();
    if_sh.we = 1; if_sh.wd = 8'h55;
    tick();
    chk("sh_after_hw", 32'(if_sh.q), 32'h55);
    chk("sh_after_hw_qe", 32'(if_sh.qe), 32'h1);

    // Reset while staged discards the stage
    if_sh.wd = 8'h66;
    tick();
    idle_all();
    rst = 1'b1;
    tick();
    chk("sh_rst_q", 32'(if_sh.q), 32'h00);
    rst = 1'b0;
    if_sh.we = 1; if_sh.wd = 8'h99;
    tick();
    idle_all();
    chk("sh_rst_nocommit", 32'(if_sh.q), 32'h00);
    chk("sh_rst_noqe", 32'(if_sh.qe), 32'h0);
    tick();
    chk("sh_rst_nocommit2", 32'(if_sh.q), 32'h00);
    chk("sh_err_st_clean", 32'(if_sh.err_storage), 32'h0);

    // Storage integrity: corrupt the shadow copy
    force u_sh.r_shadow = 8'h00;
    tick();
    chk("sh_err_st_set", 32'(if_sh.err_storage), 32'h1);
    release u_sh.r_shadow;
    tick();
    tick();
    chk("sh_err_st_sticky", 32'(if_sh.err_storage), 32'h1);
    rst = 1'b1;
    tick();
    chk("sh_err_st_rst", 32'(if_sh.err_storage), 32'h0);
    rst = 1'b0;
    tick();
    chk("sh_err_st_after", 32'(if_sh.err_storage), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
